// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Build option ALU_ARB_FIXED_PRIO_EN is consumed by rr_arb2, not here.
package alu_arb_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 5;

    localparam logic [CTRL_W-1:0] ALU_ADD = 5'd0;
    localparam logic [CTRL_W-1:0] ALU_SUB = 5'd1;
    localparam logic [CTRL_W-1:0] ALU_AND = 5'd2;
    localparam logic [CTRL_W-1:0] ALU_OR  = 5'd3;
    localparam logic [CTRL_W-1:0] ALU_SLL = 5'd4;
    localparam logic [CTRL_W-1:0] ALU_SRA = 5'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] operand_a;
        logic [DATA_W-1:0] operand_b;
        logic [CTRL_W-1:0] opcode;
        logic [CTRL_W-1:0] shiftamt;
    } alu_op_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              is_not_equal;
        logic              is_less_than;
        logic              overflow;
    } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin on last_grant, or fixed priority to port 0
// when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = 2'b00;
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end
`else
    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters (IDLE/EXEC/RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to port 0; default is round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_operandA,
    input  logic [DATA_W-1:0] req0_operandB,
    input  logic [CTRL_W-1:0] req0_ALUopcode,
    input  logic [CTRL_W-1:0] req0_shiftamt,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_operandA,
    input  logic [DATA_W-1:0] req1_operandB,
    input  logic [CTRL_W-1:0] req1_ALUopcode,
    input  logic [CTRL_W-1:0] req1_shiftamt,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_isNotEqual,
    output logic              resp0_isLessThan,
    output logic              resp0_overflow,

    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_isNotEqual,
    output logic              resp1_isLessThan,
    output logic              resp1_overflow,

    output logic [DATA_W-1:0] alu_operandA,
    output logic [DATA_W-1:0] alu_operandB,
    output logic [CTRL_W-1:0] alu_opcode,
    output logic [CTRL_W-1:0] alu_shiftamt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_isNotEqual,
    input  logic              alu_isLessThan,
    input  logic              alu_overflow
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    alu_op_t    op_q, op_d;
    alu_rsp_t   rsp_q, rsp_d;
    logic [1:0] resp_valid_q, resp_valid_d;

    alu_op_t    req0_op;
    alu_op_t    req1_op;
    alu_rsp_t   alu_rsp;
    logic [1:0] arb_valid;
    logic [1:0] grant;
    logic       owner_resp_ready;

    assign req0_op = '{operand_a: req0_operandA, operand_b: req0_operandB,
                       opcode: req0_ALUopcode, shiftamt: req0_shiftamt};
    assign req1_op = '{operand_a: req1_operandA, operand_b: req1_operandB,
                       opcode: req1_ALUopcode, shiftamt: req1_shiftamt};
    assign alu_rsp = '{result: alu_result, is_not_equal: alu_isNotEqual,
                       is_less_than: alu_isLessThan, overflow: alu_overflow};

    // Arbitration is only offered in IDLE, so ready can never fire mid-operation.
    assign arb_valid = {req1_valid, req0_valid} & {2{state_q == IDLE}};

    rr_arb2 u_rr_arb2 (
        .valid      (arb_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign owner_resp_ready = owner_q ? resp1_ready : resp0_ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        rsp_d        = rsp_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    op_d         = grant[1] ? req1_op : req0_op;
                    owner_d      = grant[1];
                    last_grant_d = grant[1];
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_d        = alu_rsp;
                resp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d      = RESP;
            end
            RESP: begin
                if (owner_resp_ready) begin
                    resp_valid_d = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 2'b00;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            rsp_q        <= '0;
            resp_valid_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            rsp_q        <= rsp_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign alu_operandA = op_q.operand_a;
    assign alu_operandB = op_q.operand_b;
    assign alu_opcode   = op_q.opcode;
    assign alu_shiftamt = op_q.shiftamt;

    // Response data is shared; only the owner's valid is ever raised.
    assign resp0_valid      = resp_valid_q[0];
    assign resp0_result     = rsp_q.result;
    assign resp0_isNotEqual = rsp_q.is_not_equal;
    assign resp0_isLessThan = rsp_q.is_less_than;
    assign resp0_overflow   = rsp_q.overflow;

    assign resp1_valid      = resp_valid_q[1];
    assign resp1_result     = rsp_q.result;
    assign resp1_isNotEqual = rsp_q.is_not_equal;
    assign resp1_isLessThan = rsp_q.is_less_than;
    assign resp1_overflow   = rsp_q.overflow;

    a_grant_onehot : assert property (@(posedge clock) disable iff (reset)
        $onehot0({req1_ready, req0_ready}));
    a_resp_onehot : assert property (@(posedge clock) disable iff (reset)
        $onehot0({resp1_valid, resp0_valid}));
    a_resp0_stable : assert property (@(posedge clock) disable iff (reset)
        (resp0_valid && !resp0_ready) |=> $stable(resp0_result));
    a_resp1_stable : assert property (@(posedge clock) disable iff (reset)
        (resp1_valid && !resp1_ready) |=> $stable(resp1_result));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_operandA, req0_operandB, req1_operandA, req1_operandB;
    logic [4:0]  req0_ALUopcode, req0_shiftamt, req1_ALUopcode, req1_shiftamt;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_isNotEqual, resp0_isLessThan, resp0_overflow;
    logic        resp1_isNotEqual, resp1_isLessThan, resp1_overflow;
    logic [31:0] alu_operandA, alu_operandB, alu_result;
    logic [4:0]  alu_opcode, alu_shiftamt;
    logic        alu_isNotEqual, alu_isLessThan, alu_overflow;

    int checks = 0;
    int failures = 0;

    alu_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_operandA(req0_operandA), .req0_operandB(req0_operandB),
        .req0_ALUopcode(req0_ALUopcode), .req0_shiftamt(req0_shiftamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_operandA(req1_operandA), .req1_operandB(req1_operandB),
        .req1_ALUopcode(req1_ALUopcode), .req1_shiftamt(req1_shiftamt),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp0_isNotEqual(resp0_isNotEqual), .resp0_isLessThan(resp0_isLessThan),
        .resp0_overflow(resp0_overflow),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .resp1_isNotEqual(resp1_isNotEqual), .resp1_isLessThan(resp1_isLessThan),
        .resp1_overflow(resp1_overflow),
        .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
        .alu_opcode(alu_opcode), .alu_shiftamt(alu_shiftamt),
        .alu_result(alu_result), .alu_isNotEqual(alu_isNotEqual),
        .alu_isLessThan(alu_isLessThan), .alu_overflow(alu_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the external shared ALU.
    always_comb begin
        alu_result = 32'd0;
        case (alu_opcode)
            5'd0: alu_result = alu_operandA + alu_operandB;
            5'd1: alu_result = alu_operandA - alu_operandB;
            5'd2: alu_result = alu_operandA & alu_operandB;
            5'd3: alu_result = alu_operandA | alu_operandB;
            5'd4: alu_result = alu_operandA << alu_shiftamt;
            5'd5: alu_result = $signed(alu_operandA) >>> alu_shiftamt;
            default: alu_result = 32'd0;
        endcase
        alu_isNotEqual = (alu_operandA != alu_operandB);
        alu_isLessThan = ($signed(alu_operandA) < $signed(alu_operandB));
        alu_overflow = 1'b0;
        if (alu_opcode == 5'd0)
            alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
        else if (alu_opcode == 5'd1)
            alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ov;
    } vec_t;

    vec_t vecs [11];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input logic port, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] op, input logic [4:0] sh, input logic v);
        if (!port) begin
            req0_valid = v; req0_operandA = a; req0_operandB = b;
            req0_ALUopcode = op; req0_shiftamt = sh;
        end else begin
            req1_valid = v; req1_operandA = a; req1_operandB = b;
            req1_ALUopcode = op; req1_shiftamt = sh;
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        drive_req(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        drive_req(1'b1, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_ready(input logic port, output logic got);
        int n;
        n = 0;
        while (!(port ? req1_ready : req0_ready) && n < 8) begin
            @(negedge clock);
            #1;
            n++;
        end
        got = port ? req1_ready : req0_ready;
    endtask

    task automatic do_vec(input vec_t v);
        logic got;
        @(negedge clock);
        drive_req(v.port, v.a, v.b, v.op, v.sh, 1'b1);
        #1;
        wait_ready(v.port, got);
        chk1("vec_req_ready", got, 1'b1);
        chk1("vec_other_ready", v.port ? req0_ready : req1_ready, 1'b0);
        if (got) begin
            @(negedge clock);
            drive_req(v.port, v.a, v.b, v.op, v.sh, 1'b0);
            chk32("vec_alu_opA", alu_operandA, v.a);
            chk32("vec_alu_opB", alu_operandB, v.b);
            chk32("vec_alu_ctrl", {22'd0, alu_opcode, alu_shiftamt}, {22'd0, v.op, v.sh});
            chk1("vec_exec_resp_valid", v.port ? resp1_valid : resp0_valid, 1'b0);
            @(negedge clock);
            chk1("vec_resp_valid", v.port ? resp1_valid : resp0_valid, 1'b1);
            chk1("vec_other_resp_valid", v.port ? resp0_valid : resp1_valid, 1'b0);
            chk32("vec_result", v.port ? resp1_result : resp0_result, v.res);
            chk1("vec_ne", v.port ? resp1_isNotEqual : resp0_isNotEqual, v.ne);
            chk1("vec_lt", v.port ? resp1_isLessThan : resp0_isLessThan, v.lt);
            chk1("vec_ov", v.port ? resp1_overflow : resp0_overflow, v.ov);
            if (v.port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
            @(negedge clock);
            resp0_ready = 1'b0;
            resp1_ready = 1'b0;
            chk1("vec_resp_done", v.port ? resp1_valid : resp0_valid, 1'b0);
        end else begin
            drive_req(v.port, v.a, v.b, v.op, v.sh, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        logic w;
        logic exp_w;

        //          port  a              b              op    sh     result         ne    lt    ov
        vecs[0]  = '{1'b0, 32'd5,        32'd7,        5'd0, 5'd0,  32'd12,        1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'd3,        32'd9,        5'd1, 5'd0,  32'hFFFFFFFA,  1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd2, 5'd0,  32'h00F000F0,  1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h000000F0, 32'h0000000F, 5'd3, 5'd0,  32'h000000FF,  1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h80000000, 32'd0,        5'd5, 5'd4,  32'hF8000000,  1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'd1,        32'd0,        5'd4, 5'd31, 32'h80000000,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h7FFFFFFF, 32'd1,        5'd0, 5'd0,  32'h80000000,  1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 32'h80000000, 32'd1,        5'd1, 5'd0,  32'h7FFFFFFF,  1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 32'd5,        32'd5,        5'd6, 5'd0,  32'd0,         1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'd3,        32'd2,        5'd7, 5'd3,  32'd0,         1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'd9,        32'd9,        5'd1, 5'd0,  32'd0,         1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        drive_req(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        drive_req(1'b1, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        apply_reset();
        chk1("rst_req0_ready", req0_ready, 1'b0);
        chk1("rst_req1_ready", req1_ready, 1'b0);
        chk1("rst_resp0_valid", resp0_valid, 1'b0);
        chk1("rst_resp1_valid", resp1_valid, 1'b0);
        chk32("rst_alu_opA", alu_operandA, 32'd0);
        chk32("rst_alu_opB", alu_operandB, 32'd0);
        chk32("rst_alu_ctrl", {22'd0, alu_opcode, alu_shiftamt}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_vec(vecs[i]);
        end

        // Sustained contention from reset: port 0 first, then alternate.
        apply_reset();
        drive_req(1'b0, 32'd3, 32'd9, 5'd1, 5'd0, 1'b1);
        drive_req(1'b1, 32'h000000F0, 32'h0000000F, 5'd3, 5'd0, 1'b1);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int n = 0; n < 8 && !got; n++) begin
                if (req0_ready || req1_ready) got = 1'b1;
                else begin @(negedge clock); #1; end
            end
            chk1("rr_accept_seen", got, 1'b1);
            chk1("rr_onehot", req0_ready & req1_ready, 1'b0);
            w = req1_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_w = 1'b0;
`else
            exp_w = k[0];
`endif
            chk1("rr_grant_port", w, exp_w);
            @(negedge clock);
            chk1("rr_exec_no_ready", req0_ready | req1_ready, 1'b0);
            @(negedge clock);
            chk1("rr_resp_valid", w ? resp1_valid : resp0_valid, 1'b1);
            chk1("rr_other_resp", w ? resp0_valid : resp1_valid, 1'b0);
            chk32("rr_result", w ? resp1_result : resp0_result, w ? 32'h000000FF : 32'hFFFFFFFA);
            @(negedge clock);
            #1;
        end

        // Response backpressure with port 1 waiting.
        apply_reset();
        drive_req(1'b0, 32'd5, 32'd7, 5'd0, 5'd0, 1'b1);
        drive_req(1'b1, 32'hAAAA0000, 32'h0000FFFF, 5'd2, 5'd0, 1'b1);
        #1;
        chk1("bp_req0_ready", req0_ready, 1'b1);
        chk1("bp_req1_ready_idle", req1_ready, 1'b0);
        @(negedge clock);
        req0_valid = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            chk1("bp_resp0_valid", resp0_valid, 1'b1);
            chk32("bp_resp0_result", resp0_result, 32'd12);
            chk1("bp_req1_ready", req1_ready, 1'b0);
            chk1("bp_resp1_valid", resp1_valid, 1'b0);
            @(negedge clock);
        end
        resp0_ready = 1'b1;
        @(negedge clock);
        resp0_ready = 1'b0;
        chk1("bp_resp0_done", resp0_valid, 1'b0);
        chk1("bp_req1_ready_after", req1_ready, 1'b1);
        req1_valid = 1'b0;

        // Reset while EXEC drops the operation.
        apply_reset();
        drive_req(1'b0, 32'd5, 32'd7, 5'd0, 5'd0, 1'b1);
        resp0_ready = 1'b1;
        #1;
        chk1("rx_req0_ready", req0_ready, 1'b1);
        @(negedge clock);
        req0_valid = 1'b0;
        chk32("rx_exec_opA", alu_operandA, 32'd5);
        reset = 1'b1;
        @(negedge clock);
        chk1("rx_req0_ready_rst", req0_ready, 1'b0);
        chk1("rx_resp0_valid_rst", resp0_valid, 1'b0);
        chk32("rx_alu_opA_rst", alu_operandA, 32'd0);
        chk32("rx_alu_opB_rst", alu_operandB, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk1("rx_no_resp", resp0_valid | resp1_valid, 1'b0);
        end
        resp0_ready = 1'b0;
        do_vec(vecs[6]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
